// File: rtl/alu_drv_pkg.sv
// Shared constants for the ALU tile pin driver: opcodes, FSM states,
// flag indices and ui_in bit positions.
package alu_drv_pkg;

    localparam int ALU_W = 4;

    localparam logic [1:0] OP_NOR  = 2'd0;
    localparam logic [1:0] OP_NAND = 2'd1;
    localparam logic [1:0] OP_ADD  = 2'd2;
    localparam logic [1:0] OP_SUB  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_A  = 3'd1,
        S_LOAD_B  = 3'd2,
        S_LOAD_OP = 3'd3,
        S_UPDATE  = 3'd4,
        S_SAMPLE  = 3'd5,
        S_RESP    = 3'd6
    } state_t;

    localparam int FLAG_V   = 4;
    localparam int FLAG_C   = 3;
    localparam int FLAG_Z   = 2;
    localparam int FLAG_NEG = 1;
    localparam int FLAG_P   = 0;

    localparam int UI_DATA_LSB = 4;
    localparam int UI_LOAD_A   = 3;
    localparam int UI_LOAD_B   = 2;
    localparam int UI_LOAD_OP  = 1;
    localparam int UI_UPDATE   = 0;

endpackage

// File: rtl/alu_drv_model.sv
// Combinational golden ALU used to cross-check sampled results.
// Only built when ALU_DRV_CHECK_EN is defined.
`ifdef ALU_DRV_CHECK_EN
module alu_drv_model
    import alu_drv_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    output logic [N-1:0] result,
    output logic [4:0]   flags
);

    logic [N:0] sum;
    logic       c;
    logic       v;

    always_comb begin
        sum = '0;
        c   = 1'b0;
        v   = 1'b0;
        unique case (op)
            OP_NOR:  sum = {1'b0, ~(a | b)};
            OP_NAND: sum = {1'b0, ~(a & b)};
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                c   = sum[N];
                v   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            default: begin
                sum = {1'b0, a} - {1'b0, b};
                c   = sum[N];
                v   = (a[N-1] != b[N-1]) && (sum[N-1] != a[N-1]);
            end
        endcase
        result           = sum[N-1:0];
        flags            = '0;
        flags[FLAG_V]    = v;
        flags[FLAG_C]    = c;
        flags[FLAG_Z]    = (sum[N-1:0] == '0);
        flags[FLAG_NEG]  = sum[N-1];
        flags[FLAG_P]    = ~^sum[N-1:0];
    end

endmodule
`endif

// File: rtl/alu_pin_driver.sv
// Host-side initiator serialising one ALU op onto the tile's ui_in strobes.
// Define ALU_DRV_CHECK_EN to add a golden-model check driving rsp_err.
module alu_pin_driver
    import alu_drv_pkg::*;
#(
    parameter int N = ALU_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    input  logic [1:0]   req_op,
    output logic [7:0]   alu_ui,
    input  logic [7:0]   alu_uo,
    input  logic [7:0]   alu_uio,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic [4:0]   rsp_flags,
    output logic         rsp_err
);

    state_t       state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [1:0]   op_q, op_d;
    logic [N-1:0] res_q, res_d;
    logic [4:0]   flags_q, flags_d;
    logic         err_q, err_d;
    logic         chk_err;
    logic         unused_uio;

    assign unused_uio = ^alu_uio[6:0];

`ifdef ALU_DRV_CHECK_EN
    logic [N-1:0] exp_res;
    logic [4:0]   exp_flags;

    alu_drv_model #(.N(N)) u_model (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (exp_res),
        .flags  (exp_flags)
    );

    assign chk_err = (exp_res != alu_uo[7:4]) ||
                     (exp_flags != {alu_uio[7], alu_uo[3:0]});
`else
    assign chk_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flags_d = flags_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = req_op;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A:  state_d = S_LOAD_B;
            S_LOAD_B:  state_d = S_LOAD_OP;
            S_LOAD_OP: state_d = S_UPDATE;
            S_UPDATE:  state_d = S_SAMPLE;
            S_SAMPLE: begin
                // ALU result register was updated at the end of UPDATE
                res_d   = alu_uo[7:4];
                flags_d = {alu_uio[7], alu_uo[3:0]};
                err_d   = chk_err;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        alu_ui = '0;
        case (state_q)
            S_LOAD_A: begin
                alu_ui[UI_DATA_LSB +: N] = a_q;
                alu_ui[UI_LOAD_A]        = 1'b1;
            end
            S_LOAD_B: begin
                alu_ui[UI_DATA_LSB +: N] = b_q;
                alu_ui[UI_LOAD_B]        = 1'b1;
            end
            S_LOAD_OP: begin
                alu_ui[UI_DATA_LSB +: 2] = op_q;
                alu_ui[UI_LOAD_OP]       = 1'b1;
            end
            S_UPDATE: alu_ui[UI_UPDATE] = 1'b1;
            default:  alu_ui = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_result = res_q;
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;

endmodule
